// File: rtl/signed_adder_4bit.sv
// Registered 4-bit two's-complement adder with signed-overflow flag.
// Latency: 1 cycle (A/B sampled at edge N appear on SUM/overflow just after edge N).
// Backpressure: none; accepts a new operand pair and emits a result every cycle.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset (clears SUM and overflow)
//   A, B     in   4  signed operands, -8..+7
//   SUM      out  4  registered (A + B) mod 16
//   overflow out  1  registered, set when the true sum leaves -8..+7
module signed_adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] SUM,
  output logic       overflow
);

  // One full-adder stage: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    logic p;
    p = a ^ b;
    return {(a & b) | (cin & p), p ^ cin};
  endfunction

  // Carries kept as separate nets so each stage depends only on the previous one.
  logic       c1, c2, c3, c4;
  logic [3:0] s;
  logic       sum_ovf;

  assign {c1, s[0]} = full_add(A[0], B[0], 1'b0);
  assign {c2, s[1]} = full_add(A[1], B[1], c1);
  assign {c3, s[2]} = full_add(A[2], B[2], c2);
  assign {c4, s[3]} = full_add(A[3], B[3], c3);

  // Signed overflow: carry into the sign bit differs from carry out of it.
  // c4 itself is only needed here; the result is the wrapped low 4 bits.
  assign sum_ovf = c4 ^ c3;

  always_ff @(posedge clk) begin
    if (rst) begin
      SUM      <= 4'b0000;
      overflow <= 1'b0;
    end else begin
      SUM      <= s;
      overflow <= sum_ovf;
    end
  end

endmodule

// File: tb/tb_signed_adder_4bit.sv
module tb_signed_adder_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] SUM;
  logic       overflow;

  int compared;
  int mismatched;

  signed_adder_4bit dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .SUM      (SUM),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    A   = 4'b0111;
    B   = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (SUM !== 4'b0000 || overflow !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold[%0d]: got SUM=%b ovf=%b, want SUM=0000 ovf=0", i, SUM, overflow);
      end
    end
    rst = 1'b0;
    step();
    compared++;
    if (SUM !== 4'b1110 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release: got SUM=%b ovf=%b, want SUM=1110 ovf=1", SUM, overflow);
    end
  endtask

  task automatic test_directed();
    logic [3:0] va [5];
    logic [3:0] vb [5];
    logic [3:0] es [5];
    logic       eo [5];
    // +2+3, +6+5, -6-4, -3-5, +7-8
    va = '{4'b0010, 4'b0110, 4'b1010, 4'b1101, 4'b0111};
    vb = '{4'b0011, 4'b0101, 4'b1100, 4'b1011, 4'b1000};
    es = '{4'b0101, 4'b1011, 4'b0110, 4'b1000, 4'b1111};
    eo = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b0};
    for (int i = 0; i < 5; i++) begin
      A = va[i];
      B = vb[i];
      step();
      compared++;
      if (SUM !== es[i] || overflow !== eo[i]) begin
        mismatched++;
        $display("FAIL directed[%0d] A=%b B=%b: got SUM=%b ovf=%b, want SUM=%b ovf=%b",
                 i, va[i], vb[i], SUM, overflow, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_hold_between_edges();
    logic [3:0] held_sum;
    logic       held_ovf;
    A = 4'b0110;
    B = 4'b0101;
    step();
    held_sum = 4'b1011;
    held_ovf = 1'b1;
    // Change inputs mid-cycle; outputs must not follow until the next edge.
    A = 4'b0001;
    B = 4'b0001;
    #2;
    compared++;
    if (SUM !== held_sum || overflow !== held_ovf) begin
      mismatched++;
      $display("FAIL no_glitch: got SUM=%b ovf=%b, want SUM=%b ovf=%b", SUM, overflow, held_sum, held_ovf);
    end
    step();
    compared++;
    if (SUM !== 4'b0010 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL after_change: got SUM=%b ovf=%b, want SUM=0010 ovf=0", SUM, overflow);
    end
  endtask

  task automatic test_midstream_reset();
    A   = 4'b0111;
    B   = 4'b0001;
    rst = 1'b1;
    step();
    compared++;
    if (SUM !== 4'b0000 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL midstream_reset: got SUM=%b ovf=%b, want SUM=0000 ovf=0", SUM, overflow);
    end
    rst = 1'b0;
    step();
    compared++;
    if (SUM !== 4'b1000 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL midstream_release: got SUM=%b ovf=%b, want SUM=1000 ovf=1", SUM, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int         t;
    logic [3:0] exp_sum;
    logic       exp_ovf;
    logic [3:0] av;
    logic [3:0] bv;
    for (int i = 0; i < 256; i++) begin
      av = i[7:4];
      bv = i[3:0];
      A  = av;
      B  = bv;
      t  = int'($signed(av)) + int'($signed(bv));
      exp_sum = t[3:0];
      exp_ovf = (t > 7) || (t < -8);
      step();
      compared++;
      if (SUM !== exp_sum || overflow !== exp_ovf) begin
        mismatched++;
        $display("FAIL sweep A=%b B=%b: got SUM=%b ovf=%b, want SUM=%b ovf=%b",
                 av, bv, SUM, overflow, exp_sum, exp_ovf);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    A   = 4'b0000;
    B   = 4'b0000;
    #1;
    test_reset();
    test_directed();
    test_hold_between_edges();
    test_midstream_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
